// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the ysyx_24100005 NPC core: widths, PC reset vector and opcodes.
package ysyx_24100005_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NR_REGS    = 1 << REG_ADDR_W;

    localparam logic [XLEN-1:0] PC_RESET = 32'h8000_0000;

    // RV32I major opcodes used by the decode muxes in top
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/ysyx_24100005_MuxKeyWithDefault.sv
// Key/value lookup mux: returns the data of the pair whose key matches, else default_out.
// Duplicate matching keys OR their data together, which keeps the logic a flat AND-OR tree.
module ysyx_24100005_MuxKeyWithDefault #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                     out,
    input  logic [KEY_LEN-1:0]                      key,
    input  logic [DATA_LEN-1:0]                     default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut
);

    localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

    logic                hit;
    logic [DATA_LEN-1:0] match_data;

    // Scan every pair; key sits above the data inside each pair
    always_comb begin
        hit        = 1'b0;
        match_data = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                hit        = 1'b1;
                match_data = match_data | lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
        out = hit ? match_data : default_out;
    end

endmodule

// File: rtl/ysyx_24100005_Reg.sv
// Generic enable-gated register with asynchronous active-high reset to RESET_VAL.
module ysyx_24100005_Reg #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // Reset wins over any write; otherwise load din when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_24100005_regfile_core.sv
// Integer register file: two combinational read ports, one synchronous write port, x0 hardwired to 0.
module ysyx_24100005_regfile_core
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned PAIR_LEN = ADDR_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0]       entry [DEPTH];
    logic [DEPTH*PAIR_LEN-1:0]   read_lut;

    // x0 has no storage; it is a constant zero
    assign entry[0] = '0;

    // One register per writable entry; the decoded enable is 0 whenever waddr selects another index,
    // so an unknown wen cannot disturb any entry while waddr is 0
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        logic entry_wen;
        assign entry_wen = wen & (waddr == ADDR_WIDTH'(i));

        ysyx_24100005_Reg #(
            .WIDTH     (DATA_WIDTH),
            .RESET_VAL ({DATA_WIDTH{1'b0}})
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .din  (wdata),
            .dout (entry[i]),
            .wen  (entry_wen)
        );
    end

    // Pack {index, value} pairs for the read muxes
    for (genvar i = 0; i < DEPTH; i++) begin : g_lut
        assign read_lut[i*PAIR_LEN +: PAIR_LEN] = {ADDR_WIDTH'(i), entry[i]};
    end

    // Read port 1: no bypass, so a same-cycle write is visible only after the edge
    ysyx_24100005_MuxKeyWithDefault #(
        .NR_KEY   (DEPTH),
        .KEY_LEN  (ADDR_WIDTH),
        .DATA_LEN (DATA_WIDTH)
    ) u_rs1_mux (
        .out         (rs1data),
        .key         (rs1addr),
        .default_out ({DATA_WIDTH{1'b0}}),
        .lut         (read_lut)
    );

    // Read port 2
    ysyx_24100005_MuxKeyWithDefault #(
        .NR_KEY   (DEPTH),
        .KEY_LEN  (ADDR_WIDTH),
        .DATA_LEN (DATA_WIDTH)
    ) u_rs2_mux (
        .out         (rs2data),
        .key         (rs2addr),
        .default_out ({DATA_WIDTH{1'b0}}),
        .lut         (read_lut)
    );

endmodule

// File: tb/tb_ysyx_24100005_regfile_core.sv
// Directed self-checking bench for the register file and its two primitives.
module tb_ysyx_24100005_regfile_core;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] rs1addr = '0;
    logic [AW-1:0] rs2addr = '0;
    logic [DW-1:0] rs1data;
    logic [DW-1:0] rs2data;

    // Primitive instances
    logic [6:0]       mux_key = '0;
    logic [31:0]      mux_def = 32'hDEF0_DEF0;
    logic [4*39-1:0]  mux_lut = '0;
    logic [31:0]      mux_out;

    logic        pc_rst = 1'b0;
    logic        pc_wen = 1'b0;
    logic [31:0] pc_din = '0;
    logic [31:0] pc_dout;

    logic [DW-1:0] model [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24100005_regfile_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data)
    );

    ysyx_24100005_MuxKeyWithDefault #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(32)) u_mux (
        .out         (mux_out),
        .key         (mux_key),
        .default_out (mux_def),
        .lut         (mux_lut)
    );

    ysyx_24100005_Reg #(.WIDTH(32), .RESET_VAL(32'h8000_0000)) u_pc (
        .clk  (clk),
        .rst  (pc_rst),
        .din  (pc_din),
        .dout (pc_dout),
        .wen  (pc_wen)
    );

    // Drive one write, update the model, and leave wen low just after the edge
    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        if (a != '0) model[a] = d;
        wen = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1addr = AW'(i); rs2addr = AW'(31 - i);
            #1;
            checks++;
            if (rs1data !== 32'h0 || rs2data !== 32'h0) begin
                errors++;
                $display("FAIL reset_async idx=%0d rs1=%h rs2=%h expected 0", i, rs1data, rs2data);
            end
        end
        // write edge while reset held must be ignored
        @(negedge clk);
        wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; rs1addr = 5'd5;
        @(posedge clk); #1;
        wen = 1'b0;
        checks++;
        if (rs1data !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold_write rs1=%h expected 0", rs1data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        for (int i = 0; i < 32; i += 5) begin
            rs1addr = AW'(i); rs2addr = AW'(i + 1);
            #1;
            checks++;
            if (rs1data !== 32'h0 || rs2data !== 32'h0) begin
                errors++;
                $display("FAIL reset_release idx=%0d rs1=%h rs2=%h expected 0", i, rs1data, rs2data);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEAD_BEEF);
        rs1addr = 5'd5; #1;
        checks++;
        if (rs1data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read x5 got=%h expected=%h", rs1data, 32'hDEAD_BEEF);
        end
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) continue;
            rs2addr = AW'(i); #1;
            checks++;
            if (rs2data !== 32'h0) begin
                errors++;
                $display("FAIL write_isolation x%0d got=%h expected 0", i, rs2data);
            end
        end
    endtask

    task automatic test_x0_guard();
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs1addr = 5'd0; rs2addr = 5'd0; #1;
        checks++;
        if (rs1data !== 32'h0 || rs2data !== 32'h0) begin
            errors++;
            $display("FAIL x0_guard rs1=%h rs2=%h expected 0", rs1data, rs2data);
        end
        // unknown wen with waddr 0 must leave all entries intact
        @(negedge clk);
        wen = 1'bx; waddr = 5'd0; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        wen = 1'b0;
        rs1addr = 5'd5; rs2addr = 5'd1; #1;
        checks++;
        if (rs1data !== 32'hDEAD_BEEF || rs2data !== 32'h0) begin
            errors++;
            $display("FAIL x_wen_guard rs1=%h rs2=%h expected deadbeef/0", rs1data, rs2data);
        end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd7, 32'h1);
        @(negedge clk);
        wdata = 32'h2; waddr = 5'd7; wen = 1'b1; rs2addr = 5'd7;
        #1;
        checks++;
        if (rs2data !== 32'h1) begin
            errors++;
            $display("FAIL rdw_before got=%h expected=1", rs2data);
        end
        @(posedge clk); #1;
        wen = 1'b0;
        model[7] = 32'h2;
        checks++;
        if (rs2data !== 32'h2) begin
            errors++;
            $display("FAIL rdw_after got=%h expected=2", rs2data);
        end
    endtask

    task automatic test_all_regs();
        for (int i = 1; i < 32; i++)
            write_reg(AW'(i), 32'hA500_0000 | (32'(i) << 8) | 32'(~i & 8'hFF));
        for (int i = 1; i < 32; i++) begin
            rs1addr = AW'(i); rs2addr = AW'(32 - i); #1;
            checks++;
            if (rs1data !== model[i] || rs2data !== model[32 - i]) begin
                errors++;
                $display("FAIL all_regs i=%0d rs1=%h exp=%h rs2=%h exp=%h",
                         i, rs1data, model[i], rs2data, model[32 - i]);
            end
        end
        rs1addr = 5'd19; rs2addr = 5'd19; #1;
        checks++;
        if (rs1data !== model[19] || rs2data !== model[19]) begin
            errors++;
            $display("FAIL same_index rs1=%h rs2=%h expected=%h", rs1data, rs2data, model[19]);
        end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        wen = 1'b0; waddr = 5'd3; wdata = 32'h9;
        @(posedge clk); #1;
        rs1addr = 5'd3; rs2addr = 5'd4; #1;
        checks++;
        if (rs1data !== 32'hA500_03FC || rs2data !== 32'hA500_04FB) begin
            errors++;
            $display("FAIL write_disabled rs1=%h exp=a50003fc rs2=%h exp=a50004fb", rs1data, rs2data);
        end
    endtask

    task automatic test_async_reset_mid();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        rs1addr = 5'd31; rs2addr = 5'd5; #1;
        checks++;
        if (rs1data !== 32'h0 || rs2data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid rs1=%h rs2=%h expected 0", rs1data, rs2data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        write_reg(5'd31, 32'h0BAD_F00D);
        rs1addr = 5'd31; #1;
        checks++;
        if (rs1data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL post_reset_write got=%h expected=0badf00d", rs1data);
        end
    endtask

    task automatic test_mux();
        logic [38:0] p0, p1, p2, p3;
        p0 = {7'h01, 32'h1111_1111};
        p1 = {7'h17, 32'hCAFE_0017};
        p2 = {7'h2A, 32'h0000_2A2A};
        p3 = {7'h40, 32'h4040_4040};
        mux_lut = {p3, p2, p1, p0};
        mux_key = 7'h17; #1;
        checks++;
        if (mux_out !== 32'hCAFE_0017) begin
            errors++;
            $display("FAIL mux_hit got=%h expected=cafe0017", mux_out);
        end
        mux_key = 7'h40; #1;
        checks++;
        if (mux_out !== 32'h4040_4040) begin
            errors++;
            $display("FAIL mux_hit_last got=%h expected=40404040", mux_out);
        end
        mux_key = 7'h7F; #1;
        checks++;
        if (mux_out !== 32'hDEF0_DEF0) begin
            errors++;
            $display("FAIL mux_default got=%h expected=def0def0", mux_out);
        end
        p0 = {7'h17, 32'h0000_00F0};
        mux_lut = {p3, p2, p1, p0};
        mux_key = 7'h17; #1;
        checks++;
        if (mux_out !== 32'hCAFE_00F7) begin
            errors++;
            $display("FAIL mux_dup_or got=%h expected=cafe00f7", mux_out);
        end
    endtask

    task automatic test_reg();
        @(negedge clk);
        pc_rst = 1'b1; #1;
        checks++;
        if (pc_dout !== 32'h8000_0000) begin
            errors++;
            $display("FAIL pc_reset got=%h expected=80000000", pc_dout);
        end
        pc_rst = 1'b0;
        pc_din = 32'h8000_0004; pc_wen = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pc_dout !== 32'h8000_0004) begin
            errors++;
            $display("FAIL pc_load got=%h expected=80000004", pc_dout);
        end
        pc_wen = 1'b0; pc_din = 32'h1234_0000;
        @(posedge clk); #1;
        checks++;
        if (pc_dout !== 32'h8000_0004) begin
            errors++;
            $display("FAIL pc_hold got=%h expected=80000004", pc_dout);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_x0_guard();
        test_read_during_write();
        test_all_regs();
        test_write_disabled();
        test_async_reset_mid();
        test_mux();
        test_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
